// File: rtl/rl_lj_pair_scheduler.sv
// rl_lj_pair_scheduler
//   Sequences particle-pair generation into the LJ force evaluation unit.
//   For every reference particle of the home cell, NUM_FILTER lanes (one
//   neighbor cell per lane, lane 0 = home cell) walk their neighbor particles,
//   emitting cell-memory read addresses and a pair_valid aligned with the read
//   data. Per-lane back pressure stalls a lane without losing or duplicating
//   a pair. Before moving to the next reference particle the scheduler waits
//   at least DRAIN_WAIT cycles and then for all filter buffers to be empty.
//
// Configuration macro: RL_LJ_NEWTON3_SKIP_EN
//   defined   : lane 0 starts at ref_ptr+1, so each home-cell pair is issued once.
//   undefined : lane 0 starts at 0 and silently skips the self pair (index == ref_ptr).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               1-cycle pulse, begins a home-cell pass (only honoured in IDLE)
//   ref_particle_count  home-cell particle count, sampled on start
//   neighbor_count      per-lane neighbor-cell particle counts, sampled on start
//   back_pressure       lane i may not issue while bit i is high
//   all_buffer_empty    all filter buffers empty
//   ref_rd_addr         home-cell read address (current reference particle)
//   neighbor_rd_addr    per-lane neighbor read address
//   pair_valid          per-lane pair valid, aligned with memory read data
//   ref_done            1-cycle pulse when a reference particle completes
//   busy                high whenever the scheduler is not IDLE
//   done                1-cycle pulse at the end of a pass
module rl_lj_pair_scheduler #(
  parameter int NUM_FILTER          = 4,
  parameter int PARTICLE_ADDR_WIDTH = 8,
  parameter int RD_LATENCY          = 1,
  parameter int DRAIN_WAIT          = 20
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [PARTICLE_ADDR_WIDTH-1:0]            ref_particle_count,
  input  logic [NUM_FILTER*PARTICLE_ADDR_WIDTH-1:0] neighbor_count,
  input  logic [NUM_FILTER-1:0]                     back_pressure,
  input  logic                                      all_buffer_empty,
  output logic [PARTICLE_ADDR_WIDTH-1:0]            ref_rd_addr,
  output logic [NUM_FILTER*PARTICLE_ADDR_WIDTH-1:0] neighbor_rd_addr,
  output logic [NUM_FILTER-1:0]                     pair_valid,
  output logic                                      ref_done,
  output logic                                      busy,
  output logic                                      done
);

  localparam int W   = PARTICLE_ADDR_WIDTH;
  localparam int DCW = $clog2(DRAIN_WAIT + 1);
  localparam logic [W-1:0]   ZERO_W    = {W{1'b0}};
  localparam logic [W-1:0]   ONE_W     = W'(1);
  localparam logic [DCW-1:0] DRAIN_END = DCW'(DRAIN_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    DRAIN    = 3'd2,
    NEXT_REF = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state, next_state;

  logic [W-1:0]          ref_count;
  logic [W-1:0]          ref_ptr;
  logic [W-1:0]          lane_count [NUM_FILTER];
  logic [W-1:0]          lane_ptr   [NUM_FILTER];
  logic [DCW-1:0]        drain_cnt;
  logic [NUM_FILTER-1:0] issue;

  logic [W-1:0]          cnt_src  [NUM_FILTER];
  logic [W-1:0]          init_ptr [NUM_FILTER];
  logic [W-1:0]          step_ptr [NUM_FILTER];
  logic [W-1:0]          init_ref;
  logic [NUM_FILTER-1:0] lane_active;
  logic [NUM_FILTER-1:0] issue_now;
  logic [NUM_FILTER-1:0] active_after;
  logic                  drain_at_limit;
  logic                  last_ref;
  logic                  pass_start;
  logic                  load_ptrs;
  logic                  busy_d, ref_done_d, done_d;

  // Advance a pointer by inc, saturating at limit so it never passes the count.
  function automatic logic [W-1:0] ptr_add(input logic [W-1:0] base,
                                           input logic [1:0]   inc,
                                           input logic [W-1:0] limit);
    logic [W:0] sum;
    sum = {1'b0, base} + {{(W-1){1'b0}}, inc};
    if (sum > {1'b0, limit}) begin
      ptr_add = limit;
    end else begin
      ptr_add = sum[W-1:0];
    end
  endfunction

  assign drain_at_limit = (drain_cnt == DRAIN_END);
  assign last_ref       = (ref_ptr == ref_count - ONE_W);
  assign pass_start     = (state == IDLE) && start && (ref_particle_count != ZERO_W);
  assign load_ptrs      = pass_start || ((state == NEXT_REF) && !last_ref);
  assign ref_rd_addr    = ref_ptr;

  // Lane issue decisions, pointer stepping and pointer initialisation values.
  always_comb begin
    // Reference index the lanes are initialised for on the next ISSUE entry.
    init_ref = (state == IDLE) ? ZERO_W : ref_ptr + ONE_W;
    for (int i = 0; i < NUM_FILTER; i++) begin
      cnt_src[i]     = (state == IDLE) ? neighbor_count[i*W +: W] : lane_count[i];
      lane_active[i] = (lane_ptr[i] < lane_count[i]);
      issue_now[i]   = (state == ISSUE) && lane_active[i] && !back_pressure[i];
      step_ptr[i]    = issue_now[i] ? ptr_add(lane_ptr[i], 2'd1, lane_count[i]) : lane_ptr[i];
      init_ptr[i]    = ZERO_W;
    end
`ifdef RL_LJ_NEWTON3_SKIP_EN
    init_ptr[0] = ptr_add(init_ref, 2'd1, cnt_src[0]);
`else
    // Lane 0 hops over the self pair so it costs no issue cycle.
    init_ptr[0] = ptr_add(ZERO_W, (init_ref == ZERO_W) ? 2'd1 : 2'd0, cnt_src[0]);
    step_ptr[0] = issue_now[0]
                ? ptr_add(lane_ptr[0], (lane_ptr[0] + ONE_W == ref_ptr) ? 2'd2 : 2'd1, lane_count[0])
                : lane_ptr[0];
`endif
    for (int i = 0; i < NUM_FILTER; i++) begin
      active_after[i] = (step_ptr[i] < lane_count[i]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (ref_particle_count == ZERO_W) ? DONE : ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: begin
        if (active_after == '0) begin
          next_state = DRAIN;
        end else begin
          next_state = ISSUE;
        end
      end
      DRAIN: begin
        // Buffer-empty is only trusted once the pipeline latency has elapsed.
        if (drain_at_limit && all_buffer_empty) begin
          next_state = NEXT_REF;
        end else begin
          next_state = DRAIN;
        end
      end
      NEXT_REF: next_state = last_ref ? DONE : ISSUE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // FSM output decode, registered below.
  always_comb begin
    busy_d     = (next_state != IDLE);
    ref_done_d = (state == NEXT_REF);
    done_d     = (state == DONE);
  end

  // Datapath: counts, pointers, drain counter, addresses and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_count        <= ZERO_W;
      ref_ptr          <= ZERO_W;
      drain_cnt        <= '0;
      issue            <= '0;
      neighbor_rd_addr <= '0;
      busy             <= 1'b0;
      ref_done         <= 1'b0;
      done             <= 1'b0;
      for (int i = 0; i < NUM_FILTER; i++) begin
        lane_count[i] <= ZERO_W;
        lane_ptr[i]   <= ZERO_W;
      end
    end else begin
      busy     <= busy_d;
      ref_done <= ref_done_d;
      done     <= done_d;
      issue    <= issue_now;
      if (pass_start) begin
        ref_count <= ref_particle_count;
        ref_ptr   <= ZERO_W;
      end else if ((state == NEXT_REF) && !last_ref) begin
        ref_ptr <= ref_ptr + ONE_W;
      end
      if (state == DRAIN) begin
        if (!drain_at_limit) begin
          drain_cnt <= drain_cnt + DCW'(1);
        end
      end else begin
        drain_cnt <= '0;
      end
      for (int i = 0; i < NUM_FILTER; i++) begin
        if (pass_start) begin
          lane_count[i] <= cnt_src[i];
        end
        if (load_ptrs) begin
          lane_ptr[i] <= init_ptr[i];
        end else begin
          lane_ptr[i] <= step_ptr[i];
        end
        if (issue_now[i]) begin
          neighbor_rd_addr[i*W +: W] <= lane_ptr[i];
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_no_delay
      assign pair_valid = issue;
    end else begin : g_delay
      logic [NUM_FILTER-1:0] valid_pipe [RD_LATENCY];
      // Delay issue by the memory read latency so pair_valid meets the data.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < RD_LATENCY; k++) begin
            valid_pipe[k] <= '0;
          end
        end else begin
          valid_pipe[0] <= issue;
          for (int k = 1; k < RD_LATENCY; k++) begin
            valid_pipe[k] <= valid_pipe[k-1];
          end
        end
      end
      assign pair_valid = valid_pipe[RD_LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_rl_lj_pair_scheduler.sv
// Self-checking bench for rl_lj_pair_scheduler. A one-cycle read memory model
// returns the registered addresses; each expected pair {ref, neighbor index} is
// queued per lane when a pass is launched and popped whenever pair_valid fires.
module tb_rl_lj_pair_scheduler;

  localparam int NF = 4;
  localparam int W  = 8;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  ref_particle_count;
  logic [NF*W-1:0] neighbor_count;
  logic [NF-1:0] back_pressure;
  logic          all_buffer_empty;
  logic [W-1:0]  ref_rd_addr;
  logic [NF*W-1:0] neighbor_rd_addr;
  logic [NF-1:0] pair_valid;
  logic          ref_done;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q [NF][$];
  int          lane_pairs [NF];
  int          cnt_m [NF];
  logic [W-1:0] ref_data;
  logic [W-1:0] nb_data [NF];

  int ref_dones, first_rd, done_n;
  bit early_ref_move;

  rl_lj_pair_scheduler #(
    .NUM_FILTER(NF), .PARTICLE_ADDR_WIDTH(W), .RD_LATENCY(1), .DRAIN_WAIT(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ref_particle_count(ref_particle_count), .neighbor_count(neighbor_count),
    .back_pressure(back_pressure), .all_buffer_empty(all_buffer_empty),
    .ref_rd_addr(ref_rd_addr), .neighbor_rd_addr(neighbor_rd_addr),
    .pair_valid(pair_valid), .ref_done(ref_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Cell memory model: data equals the address, one cycle of read latency.
  always @(posedge clk) begin
    ref_data <= ref_rd_addr;
    for (int i = 0; i < NF; i++) nb_data[i] <= neighbor_rd_addr[i*W +: W];
  end

  // One sample point: advance to the falling edge and consume any pairs.
  task automatic tick();
    logic [15:0] e, g;
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < NF; i++) begin
        if (pair_valid[i]) begin
          lane_pairs[i]++;
          checks++;
          g = {ref_data, nb_data[i]};
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL pair_unexpected lane=%0d got ref=%0d addr=%0d, expected no pair",
                     i, g[15:8], g[7:0]);
          end else begin
            e = exp_q[i].pop_front();
            if (g !== e) begin
              errors++;
              $display("FAIL pair_order lane=%0d got ref=%0d addr=%0d, expected ref=%0d addr=%0d",
                       i, g[15:8], g[7:0], e[15:8], e[7:0]);
            end
          end
        end
      end
    end
  endtask

  // Reference model of the pairs a pass must produce, in per-lane order.
  task automatic push_expected(input int refc);
    for (int r = 0; r < refc; r++) begin
      for (int i = 0; i < NF; i++) begin
        int lo;
        lo = 0;
`ifdef RL_LJ_NEWTON3_SKIP_EN
        if (i == 0) lo = r + 1;
`endif
        for (int a = lo; a < cnt_m[i]; a++) begin
`ifndef RL_LJ_NEWTON3_SKIP_EN
          if (i == 0 && a == r) continue;
`endif
          exp_q[i].push_back({r[7:0], a[7:0]});
        end
      end
    end
  endtask

  // Launch a pass and follow it to done; mode selects the back-pressure pattern.
  task automatic run_pass(input int refc, input int mode, input int abe_until, input int budget);
    int n;
    bit fin;
    logic [31:0] rnd;
    push_expected(refc);
    for (int i = 0; i < NF; i++) lane_pairs[i] = 0;
    ref_dones = 0; first_rd = -1; done_n = -1; early_ref_move = 1'b0;
    ref_particle_count = refc[W-1:0];
    for (int i = 0; i < NF; i++) neighbor_count[i*W +: W] = cnt_m[i][W-1:0];
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; fin = 1'b0;
    while (!fin && n < budget) begin
      tick();
      n++;
      if (ref_done) begin
        ref_dones++;
        if (first_rd < 0) first_rd = n;
      end
      if (first_rd < 0 && ref_rd_addr != 8'd0) early_ref_move = 1'b1;
      if (done) begin
        fin = 1'b1;
        done_n = n;
      end
      case (mode)
        1: back_pressure = (n >= 2 && n <= 6) ? 4'b0100 : 4'b0000;
        2: begin rnd = $urandom; back_pressure = rnd[3:0]; end
        3: begin
          start = (n == 2);
          if (n == 2) begin
            ref_particle_count = 8'd5;
            neighbor_count = {4{8'd9}};
          end
        end
        4: back_pressure = n[0] ? 4'b0101 : 4'b1010;
        default: back_pressure = 4'b0000;
      endcase
      all_buffer_empty = (n >= abe_until);
    end
    back_pressure = 4'b0000; all_buffer_empty = 1'b1; start = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL pass_timeout got no done within %0d cycles, expected done", budget);
    end
    for (int i = 0; i < NF; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL pairs_missing lane=%0d got %0d outstanding, expected 0", i, exp_q[i].size());
        exp_q[i].delete();
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, ref_done, pair_valid, ref_rd_addr, neighbor_rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b ref_done=%b pv=%b, expected all 0",
               busy, done, ref_done, pair_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < NF; i++) cnt_m[i] = 10;
    push_expected(10);
    ref_particle_count = 8'd10;
    neighbor_count = {4{8'd10}};
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_before got %b, expected 1", busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, ref_done, pair_valid, ref_rd_addr, neighbor_rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_midpass got busy=%b pv=%b addr=%h, expected all 0",
               busy, pair_valid, neighbor_rd_addr);
    end
    rst = 1'b0;
    for (int i = 0; i < NF; i++) begin exp_q[i].delete(); lane_pairs[i] = 0; end
    seen = 0;
    repeat (30) begin
      tick();
      if (pair_valid != '0 || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_quiet got %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_basic();
    int lane0_exp;
`ifdef RL_LJ_NEWTON3_SKIP_EN
    lane0_exp = 3;
`else
    lane0_exp = 4;
`endif
    cnt_m[0] = 3; cnt_m[1] = 2; cnt_m[2] = 0; cnt_m[3] = 1;
    run_pass(2, 0, 0, 400);
    checks++;
    if (lane_pairs[0] != lane0_exp || lane_pairs[1] != 4 || lane_pairs[2] != 0 || lane_pairs[3] != 2) begin
      errors++;
      $display("FAIL basic_counts got %0d/%0d/%0d/%0d, expected %0d/4/0/2",
               lane_pairs[0], lane_pairs[1], lane_pairs[2], lane_pairs[3], lane0_exp);
    end
    checks++;
    if (ref_dones != 2) begin
      errors++;
      $display("FAIL basic_ref_done got %0d, expected 2", ref_dones);
    end
    checks++;
    if (first_rd != 4 + DW) begin
      errors++;
      $display("FAIL basic_drain_time got %0d, expected %0d", first_rd, 4 + DW);
    end
    checks++;
    if (done_n != 8 + 2 * DW) begin
      errors++;
      $display("FAIL basic_done_time got %0d, expected %0d", done_n, 8 + 2 * DW);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_busy got %b, expected 0", busy);
    end
  endtask

  task automatic test_back_pressure();
    cnt_m[0] = 0; cnt_m[1] = 0; cnt_m[2] = 5; cnt_m[3] = 0;
    run_pass(1, 1, 0, 200);
    checks++;
    if (lane_pairs[2] != 5 || lane_pairs[0] + lane_pairs[1] + lane_pairs[3] != 0) begin
      errors++;
      $display("FAIL bp_lane2 got %0d (others %0d), expected 5 (others 0)",
               lane_pairs[2], lane_pairs[0] + lane_pairs[1] + lane_pairs[3]);
    end
  endtask

  task automatic test_bp_toggle();
    cnt_m[0] = 5; cnt_m[1] = 4; cnt_m[2] = 6; cnt_m[3] = 3;
    run_pass(3, 4, 0, 600);
    checks++;
    if (ref_dones != 3) begin
      errors++;
      $display("FAIL toggle_ref_done got %0d, expected 3", ref_dones);
    end
    cnt_m[0] = 6; cnt_m[1] = 7; cnt_m[2] = 2; cnt_m[3] = 5;
    run_pass(4, 2, 0, 800);
    checks++;
    if (ref_dones != 4) begin
      errors++;
      $display("FAIL random_bp_ref_done got %0d, expected 4", ref_dones);
    end
  endtask

  task automatic test_drain_hold();
    cnt_m[0] = 0; cnt_m[1] = 2; cnt_m[2] = 0; cnt_m[3] = 0;
    run_pass(2, 0, 2 + DW + 50, 400);
    checks++;
    if (first_rd != 4 + DW + 50) begin
      errors++;
      $display("FAIL drain_hold_time got %0d, expected %0d", first_rd, 4 + DW + 50);
    end
    checks++;
    if (early_ref_move) begin
      errors++;
      $display("FAIL drain_hold_ref_ptr got moved, expected held at 0");
    end
    checks++;
    if (ref_dones != 2) begin
      errors++;
      $display("FAIL drain_hold_ref_done got %0d, expected 2", ref_dones);
    end
  endtask

  task automatic test_zero_counts();
    for (int i = 0; i < NF; i++) lane_pairs[i] = 0;
    ref_particle_count = 8'd0;
    neighbor_count = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_ref_c1 got done=%b busy=%b, expected done=0 busy=1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL zero_ref_done got %b, expected 1", done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lane_pairs[0] + lane_pairs[1] + lane_pairs[2] + lane_pairs[3] != 0) begin
      errors++;
      $display("FAIL zero_ref_after got done=%b busy=%b, expected both 0 and no pairs", done, busy);
    end
    for (int i = 0; i < NF; i++) cnt_m[i] = 0;
    run_pass(1, 0, 0, 200);
    checks++;
    if (ref_dones != 1 || first_rd != 3 + DW || done_n != 4 + DW) begin
      errors++;
      $display("FAIL zero_lanes got ref_done=%0d at %0d done at %0d, expected 1 at %0d done at %0d",
               ref_dones, first_rd, done_n, 3 + DW, 4 + DW);
    end
  endtask

  task automatic test_start_busy();
    int late;
    cnt_m[0] = 2; cnt_m[1] = 2; cnt_m[2] = 2; cnt_m[3] = 2;
    run_pass(1, 3, 0, 300);
    checks++;
    if (ref_dones != 1 || lane_pairs[1] + lane_pairs[2] + lane_pairs[3] != 6) begin
      errors++;
      $display("FAIL start_busy_pass got ref_done=%0d pairs=%0d, expected 1 and 6",
               ref_dones, lane_pairs[1] + lane_pairs[2] + lane_pairs[3]);
    end
    late = 0;
    repeat (10) begin
      tick();
      if (busy || done) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL start_busy_rerun got %0d active cycles, expected 0", late);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ref_particle_count = '0; neighbor_count = '0;
    back_pressure = '0; all_buffer_empty = 1'b1;
    for (int i = 0; i < NF; i++) begin lane_pairs[i] = 0; cnt_m[i] = 0; end
    test_reset();
    test_basic();
    test_back_pressure();
    test_bp_toggle();
    test_drain_hold();
    test_zero_counts();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
